// File: rtl/data_mem_unit_pkg.sv
// Shared constants for the data-memory stage: memsize encodings and the
// default tohost MMIO address.
package data_mem_unit_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'hFFFF_FFF0;

  // True when the size encoding is defined and the offset is naturally aligned.
  function automatic logic size_legal(input logic [2:0] memsize, input logic [1:0] offs);
    case (memsize)
      MEM_B, MEM_BU: size_legal = 1'b1;
      MEM_H, MEM_HU: size_legal = ~offs[0];
      MEM_W:         size_legal = (offs == 2'b00);
      default:       size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the MEMORY stage and the data-memory unit.
// memread/memwrite are single-cycle request strobes sampled on every posedge;
// there is no backpressure, and rdata is valid in the same cycle as memread.
interface data_mem_unit_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memwrite;
  logic        memread;
  logic [2:0]  memsize;
  logic [31:0] rdata;
  logic        halt;
  logic [31:0] tohost;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] ld_cnt;
  logic [31:0] st_cnt;

  modport master (
    output addr, wdata, memwrite, memread, memsize,
    input  rdata, halt, tohost, err, err_addr, ld_cnt, st_cnt
  );

  modport slave (
    input  addr, wdata, memwrite, memread, memsize,
    output rdata, halt, tohost, err, err_addr, ld_cnt, st_cnt
  );
endinterface

// File: rtl/data_mem_unit_lane_ctl.sv
// Byte-lane steering for the data memory: legality, byte enables, replicated
// store data and sign/zero-extended load data.
module data_mem_unit_lane_ctl
  import data_mem_unit_pkg::*;
(
  input  logic [1:0]  offs_i,
  input  logic [2:0]  memsize_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic        legal_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_sh_o,
  output logic [31:0] rdata_ext_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign legal_o = size_legal(memsize_i, offs_i);
  assign rbyte   = rword_i[{offs_i, 3'b000} +: 8];
  assign rhalf   = offs_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o        = 4'b0000;
    wdata_sh_o  = wdata_i;
    rdata_ext_o = 32'd0;
    case (memsize_i)
      MEM_B, MEM_BU: begin
        be_o        = 4'b0001 << offs_i;
        wdata_sh_o  = {4{wdata_i[7:0]}};
        rdata_ext_o = (memsize_i == MEM_B) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
      end
      MEM_H, MEM_HU: begin
        be_o        = offs_i[1] ? 4'b1100 : 4'b0011;
        wdata_sh_o  = {2{wdata_i[15:0]}};
        rdata_ext_o = (memsize_i == MEM_H) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
      end
      MEM_W: begin
        be_o        = 4'b1111;
        rdata_ext_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: word RAM with byte-lane stores, zero-latency loads,
// tohost halt register, sticky error capture and access counters.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  data_mem_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] ram_q [DEPTH_WORDS];

  logic          legal;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;
  logic [AW-1:0] idx;
  logic          is_tohost, any_req, acc_err, ld_ok, st_ok, ram_we;

  logic        halt_q, halt_d, err_q, err_d;
  logic [31:0] tohost_q, tohost_d, err_addr_q, err_addr_d;
  logic [31:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;

  assign idx       = bus.addr[AW+1:2];
  assign is_tohost = (bus.addr == TOHOST_ADDR);
  assign any_req   = bus.memread | bus.memwrite;
  // Simultaneous read and write is treated like a misalignment.
  assign acc_err   = any_req & (~legal | (bus.memread & bus.memwrite));
  assign ld_ok     = bus.memread & ~bus.memwrite & legal;
  assign st_ok     = bus.memwrite & ~bus.memread & legal;
  assign ram_we    = st_ok & ~is_tohost;

  data_mem_unit_lane_ctl u_lane_ctl (
    .offs_i      (bus.addr[1:0]),
    .memsize_i   (bus.memsize),
    .wdata_i     (bus.wdata),
    .rword_i     (ram_q[idx]),
    .legal_o     (legal),
    .be_o        (be),
    .wdata_sh_o  (wdata_sh),
    .rdata_ext_o (rdata_ext)
  );

  assign bus.rdata = !ld_ok ? 32'd0 : (is_tohost ? tohost_q : rdata_ext);

  always_comb begin
    halt_d     = halt_q;
    tohost_d   = tohost_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    ld_cnt_d   = ld_cnt_q;
    st_cnt_d   = st_cnt_q;
    if (acc_err) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = bus.addr;
    end
    if (ld_ok) ld_cnt_d = ld_cnt_q + 32'd1;
    if (st_ok) begin
      st_cnt_d = st_cnt_q + 32'd1;
      if (is_tohost) begin
        tohost_d = bus.wdata;
        halt_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_q     <= 1'b0;
      tohost_q   <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
      ld_cnt_q   <= 32'd0;
      st_cnt_q   <= 32'd0;
    end else begin
      halt_q     <= halt_d;
      tohost_q   <= tohost_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      ld_cnt_q   <= ld_cnt_d;
      st_cnt_q   <= st_cnt_d;
    end
  end

  // RAM keeps its contents across reset; writes are only blocked while reset is low.
  always_ff @(posedge clk) begin
    if (reset && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram_q[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign bus.halt     = halt_q;
  assign bus.tohost   = tohost_q;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
  assign bus.ld_cnt   = ld_cnt_q;
  assign bus.st_cnt   = st_cnt_q;

endmodule
